// File: rtl/acc_shift_seq.sv
// -----------------------------------------------------------------------------
// acc_shift_seq
//   8-bit accumulator with a sequenced multi-bit left shift. The one-bit shift
//   itself lives in an external shifter stage: this block presents acc_data,
//   and the stage returns lshift_out ({acc_data[6:0],1'b0}) and ci_lshift
//   (acc_data[7]). Each SHIFT cycle commits one returned step, so an N-bit
//   shift takes N cycles followed by a one-cycle DONE pulse.
//
//   Configuration macro: ACC_ROTATE_EN
//     defined   -> input port rot exists; it is sampled on an accepted start.
//                  When it is 1, the bit leaving acc[7] re-enters at acc[0]
//                  (8-bit rotate left).
//     undefined -> no rot port; vacated bits are always zero (logical shift).
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   load        in   load acc from load_data (ignored while busy)
//   load_data   in   [7:0] load value
//   start       in   begin shift of shamt bits (ignored while busy or with load)
//   shamt       in   [2:0] shift count, sampled on accepted start
//   rot         in   rotate select (ACC_ROTATE_EN builds only)
//   lshift_out  in   [7:0] one-bit-left-shifted acc_data from shifter stage
//   ci_lshift   in   bit shifted out of acc_data[7] from shifter stage
//   acc_data    out  [7:0] registered accumulator
//   carry       out  registered carry, last bit shifted out
//   busy        out  high while shifting
//   done        out  one-cycle completion pulse
//   zero        out  combinational acc_data == 0
// -----------------------------------------------------------------------------
module acc_shift_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_data,
   input  logic       start,
   input  logic [2:0] shamt,
`ifdef ACC_ROTATE_EN
   input  logic       rot,
`endif
   input  logic [7:0] lshift_out,
   input  logic       ci_lshift,
   output logic [7:0] acc_data,
   output logic       carry,
   output logic       busy,
   output logic       done,
   output logic       zero
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_acc;
   logic [7:0] w_acc_nxt;
   logic       r_carry;
   logic       w_carry_nxt;
   logic [2:0] r_count;
   logic [2:0] w_count_nxt;
   logic       r_rot;
   logic       w_rot_nxt;

   logic       w_ready;      // IDLE or DONE: new commands may be accepted
   logic       w_load_acc;   // accepted load
   logic       w_start_acc;  // accepted start (load has priority)
   logic       w_fill;       // bit entering acc[0] on a shift step
   logic       w_rot_in;     // rot request as seen at start acceptance

`ifdef ACC_ROTATE_EN
   assign w_rot_in = rot;
`else
   assign w_rot_in = 1'b0;
`endif

   assign w_ready     = (r_state != S_SHIFT);
   assign w_load_acc  = w_ready & load;
   assign w_start_acc = w_ready & start & ~load;

   // Rotate re-injects the bit leaving acc[7]; logical shift fills with zero.
   assign w_fill = r_rot & ci_lshift;

   // ---------------------------------------------------------------------------
   // State register and datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_acc   <= 8'h00;
         r_carry <= 1'b0;
         r_count <= 3'd0;
         r_rot   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_carry <= w_carry_nxt;
         r_count <= w_count_nxt;
         r_rot   <= w_rot_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and datapath update
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_carry_nxt = r_carry;
      w_count_nxt = r_count;
      w_rot_nxt   = r_rot;

      unique case (r_state)
         S_IDLE, S_DONE: begin
            // DONE falls back to IDLE unless a new command is taken this cycle.
            w_state_nxt = S_IDLE;
            if (w_load_acc) begin
               w_acc_nxt   = load_data;
               w_carry_nxt = 1'b0;
            end else if (w_start_acc) begin
               w_rot_nxt = w_rot_in;
               if (shamt == 3'd0) begin
                  // Zero-length shift completes immediately, acc untouched.
                  w_state_nxt = S_DONE;
               end else begin
                  w_count_nxt = shamt;
                  w_state_nxt = S_SHIFT;
               end
            end
         end

         S_SHIFT: begin
            w_acc_nxt   = lshift_out | {7'b0, w_fill};
            w_carry_nxt = ci_lshift;
            w_count_nxt = r_count - 3'd1;
            if (r_count == 3'd1) begin
               w_state_nxt = S_DONE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign acc_data = r_acc;
   assign carry    = r_carry;
   assign busy     = (r_state == S_SHIFT);
   assign done     = (r_state == S_DONE);
   assign zero     = (r_acc == 8'h00);

endmodule

// File: tb/tb_acc_shift_seq.sv
// -----------------------------------------------------------------------------
// tb_acc_shift_seq
//   Directed bench for acc_shift_seq. Models the external one-bit shifter stage
//   and walks a linear sequence of loads/starts with hand-computed results.
// -----------------------------------------------------------------------------
module tb_acc_shift_seq;

   logic       clk;
   logic       rst_n;
   logic       load;
   logic [7:0] load_data;
   logic       start;
   logic [2:0] shamt;
`ifdef ACC_ROTATE_EN
   logic       rot;
`endif
   logic [7:0] lshift_out;
   logic       ci_lshift;
   logic [7:0] acc_data;
   logic       carry;
   logic       busy;
   logic       done;
   logic       zero;

   int n_chk;
   int n_err;

   acc_shift_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .load_data  (load_data),
      .start      (start),
      .shamt      (shamt),
`ifdef ACC_ROTATE_EN
      .rot        (rot),
`endif
      .lshift_out (lshift_out),
      .ci_lshift  (ci_lshift),
      .acc_data   (acc_data),
      .carry      (carry),
      .busy       (busy),
      .done       (done),
      .zero       (zero)
   );

   // External shifter stage
   assign lshift_out = {acc_data[6:0], 1'b0};
   assign ci_lshift  = acc_data[7];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_st(input string tag, input logic [7:0] a, input logic c,
                         input logic b, input logic d, input logic z);
      chk({tag, ".acc"},   acc_data, a);
      chk({tag, ".carry"}, {7'b0, carry}, {7'b0, c});
      chk({tag, ".busy"},  {7'b0, busy},  {7'b0, b});
      chk({tag, ".done"},  {7'b0, done},  {7'b0, d});
      chk({tag, ".zero"},  {7'b0, zero},  {7'b0, z});
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0; load = 1'b0; load_data = 8'h00; start = 1'b0; shamt = 3'd0;
`ifdef ACC_ROTATE_EN
      rot = 1'b0;
`endif
      #3;
      chk_st("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // load 96, shift 1 -> 2C carry 1, done 2 cycles after start
      load = 1'b1; load_data = 8'h96;
      tick();
      load = 1'b0;
      chk_st("ld96", 8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
      start = 1'b1; shamt = 3'd1;
      tick();
      start = 1'b0;
      chk_st("sh1_c1", 8'h96, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk_st("sh1_done", 8'h2C, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_st("sh1_idle", 8'h2C, 1'b1, 1'b0, 1'b0, 1'b0);

      // load 81, shift 7 -> busy 7 cycles, 80 carry 0; shamt changed mid-shift
      load = 1'b1; load_data = 8'h81;
      tick();
      load = 1'b0;
      start = 1'b1; shamt = 3'd7;
      tick();
      start = 1'b0; shamt = 3'd2;
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("sh7_busy%0d", i), {6'b0, busy, done}, 8'h02);
         tick();
      end
      chk_st("sh7_done", 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();

      // load 5A, shift 0 -> done next cycle, never busy
      load = 1'b1; load_data = 8'h5A;
      tick();
      load = 1'b0;
      start = 1'b1; shamt = 3'd0;
      tick();
      start = 1'b0;
      chk_st("sh0_done", 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_st("sh0_idle", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

      // load and start together: start ignored
      load = 1'b1; load_data = 8'h40; start = 1'b1; shamt = 3'd3;
      tick();
      load = 1'b0; start = 1'b0;
      chk_st("ldst", 8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_st("ldst_idle", 8'h40, 1'b0, 1'b0, 1'b0, 1'b0);

      // FF shift 3 with load/start mid-shift ignored -> F8 carry 1
      load = 1'b1; load_data = 8'hFF;
      tick();
      load = 1'b0;
      start = 1'b1; shamt = 3'd3;
      tick();
      start = 1'b0;
      tick();
      load = 1'b1; load_data = 8'h11; start = 1'b1; shamt = 3'd5;
      tick();
      load = 1'b0; start = 1'b0;
      chk_st("shFF_mid", 8'hFC, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      chk_st("shFF_done", 8'hF8, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_st("shFF_idle", 8'hF8, 1'b1, 1'b0, 1'b0, 1'b0);

      // C3 shift 6, async reset after 3 shift cycles
      load = 1'b1; load_data = 8'hC3;
      tick();
      load = 1'b0;
      start = 1'b1; shamt = 3'd6;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk_st("shC3_pre", 8'h18, 1'b0, 1'b1, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk_st("shC3_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(); tick();
      #2 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("no_done%0d", i), {6'b0, busy, done}, 8'h00);
      end

      // first load after reset release is accepted
      load = 1'b1; load_data = 8'h7E;
      tick();
      load = 1'b0;
      chk_st("ld7E", 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);

      // start accepted in the DONE cycle (back-to-back)
      start = 1'b1; shamt = 3'd0;
      tick();
      shamt = 3'd2;
      tick();
      start = 1'b0;
      chk_st("b2b_c1", 8'h7E, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(); tick();
      chk_st("b2b_done", 8'hF8, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();

`ifdef ACC_ROTATE_EN
      load = 1'b1; load_data = 8'h81;
      tick();
      load = 1'b0;
      start = 1'b1; shamt = 3'd1; rot = 1'b1;
      tick();
      start = 1'b0; rot = 1'b0;
      tick();
      chk_st("rot1", 8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      load = 1'b1; load_data = 8'h81;
      tick();
      load = 1'b0;
      start = 1'b1; shamt = 3'd1; rot = 1'b0;
      tick();
      start = 1'b0;
      tick();
      chk_st("rot0", 8'h02, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
